// File: rtl/mcu_mem_pkg.sv
// mcu_mem_pkg: shared source/lock encodings and default widths for the memory port arbiter
package mcu_mem_pkg;
  localparam int ADDR_WIDTH_DEF = 32;
  localparam int DATA_WIDTH_DEF = 32;
  typedef enum logic {SRC_INSTR = 1'b0, SRC_DATA = 1'b1} mem_src_e;
  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} lock_state_e;
  function automatic mem_src_e rr_pick(input logic instr_req, input logic data_req, input mem_src_e last_src);
    return (instr_req & data_req) ? ((last_src == SRC_DATA) ? SRC_INSTR : SRC_DATA) :
           data_req ? SRC_DATA : SRC_INSTR;
  endfunction
endpackage

// File: rtl/mem_arb_tag_fifo.sv
// mem_arb_tag_fifo: in-order FIFO of granted sources, one entry per outstanding transaction
module mem_arb_tag_fifo
  import mcu_mem_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  logic     pop,
  input  mem_src_e din,
  output logic     full,
  output logic     empty,
  output mem_src_e head
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  mem_src_e       mem [DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= nxt(wr_ptr);
      end
      if (pop) rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one req/gnt/rvalid memory port between fetch and load/store
module mem_port_arbiter
  import mcu_mem_pkg::*;
#(
  parameter int ADDR_WIDTH      = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH      = DATA_WIDTH_DEF,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    instr_req_i,
  output logic                    instr_gnt_o,
  output logic                    instr_rvalid_o,
  input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
  output logic [DATA_WIDTH-1:0]   instr_rdata_o,
  input  logic                    data_req_i,
  output logic                    data_gnt_o,
  output logic                    data_rvalid_o,
  input  logic                    data_we_i,
  input  logic [DATA_WIDTH/8-1:0] data_be_i,
  input  logic [ADDR_WIDTH-1:0]   data_addr_i,
  input  logic [DATA_WIDTH-1:0]   data_wdata_i,
  output logic [DATA_WIDTH-1:0]   data_rdata_o,
  output logic                    data_err_o,
  output logic                    mem_req_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  input  logic                    mem_err_i,
  output logic                    protocol_err_o
);
  lock_state_e state;
  mem_src_e    lock_src, last_src, sel, head;
  logic        full, empty, sel_req, is_data, push, pop;
  assign sel     = (state == LOCKED) ? lock_src : rr_pick(instr_req_i, data_req_i, last_src);
  assign is_data = (sel == SRC_DATA);
  assign sel_req = is_data ? data_req_i : instr_req_i;
  // A full FIFO blocks new requests even if a response frees a slot this cycle
  assign mem_req_o   = !rst_i & sel_req & !full;
  assign push        = mem_req_o & mem_gnt_i;
  assign pop         = !rst_i & mem_rvalid_i & !empty;
  assign instr_gnt_o = push & !is_data;
  assign data_gnt_o  = push & is_data;
  assign mem_we_o    = is_data & data_we_i;
  assign mem_be_o    = is_data ? data_be_i : '1;
  assign mem_addr_o  = is_data ? data_addr_i : instr_addr_i;
  assign mem_wdata_o = is_data ? data_wdata_i : '0;
  assign instr_rvalid_o = pop & (head == SRC_INSTR);
  assign data_rvalid_o  = pop & (head == SRC_DATA);
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;
  assign data_err_o     = data_rvalid_o & mem_err_i;
  mem_arb_tag_fifo #(.DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (push),
    .pop   (pop),
    .din   (sel),
    .full  (full),
    .empty (empty),
    .head  (head)
  );
  // Lock holds the mux on the chosen source until the memory accepts it
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= UNLOCKED;
      lock_src       <= SRC_INSTR;
      last_src       <= SRC_DATA;
      protocol_err_o <= 1'b0;
    end else begin
      state <= (state == UNLOCKED) ? ((mem_req_o & !mem_gnt_i) ? LOCKED : UNLOCKED)
                                   : ((mem_gnt_i | !mem_req_o) ? UNLOCKED : LOCKED);
      if (state == UNLOCKED) lock_src <= sel;
      if (push) last_src <= sel;
      if (mem_rvalid_i & empty) protocol_err_o <= 1'b1;
    end
  end
endmodule
